// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and fill-engine state encoding.
// The scan-out block uses the same geometry constants.
package vga_pkg;

  localparam int unsigned FB_W_WORDS = 80;
  localparam int unsigned FB_H       = 120;
  localparam int unsigned FB_WORDS   = FB_W_WORDS * FB_H;
  localparam int unsigned ADDR_W     = 15;
  localparam int unsigned DATA_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/vga_fb_arb.sv
// Fixed-priority (CPU over fill) framebuffer write mux with output register.
// When neither source writes, the write enable drops and addr/data hold.
module vga_fb_arb
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_grant_c,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [DATA_W-1:0] fb_data
);

  assign fill_grant_c = fill_req & ~cpu_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr <= '0;
      fb_data <= '0;
      fb_we   <= 1'b0;
    end else if (cpu_we) begin
      fb_addr <= cpu_addr;
      fb_data <= cpu_data;
      fb_we   <= 1'b1;
    end else if (fill_req) begin
      fb_addr <= fill_addr;
      fb_data <= fill_data;
      fb_we   <= 1'b1;
    end else begin
      fb_we   <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_fill.sv
// Rectangle-fill engine merged with CPU single-word writes onto the
// framebuffer write port. CPU writes always win; the fill stalls around them.
module vga_fill
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [6:0]        cmd_x,
  input  logic [6:0]        cmd_y,
  input  logic [7:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [DATA_W-1:0] fb_data
);

  fill_state_t       state, state_next;
  logic [6:0]        x_q, y_q, col, row, x_end, y_end;
  logic [7:0]        w_q, h_q;
  logic [DATA_W-1:0] color;
  logic [ADDR_W-1:0] row_base;

  logic              accept_c, empty_c, last_col_c, last_row_c;
  logic              fill_req_c, fill_grant_c;
  logic [ADDR_W-1:0] fill_addr_c, row_base_c;
  logic [8:0]        x_sum_c, y_sum_c;
  logic [6:0]        x_end_c, y_end_c;

  // Clip computations, evaluated while in SETUP from the latched command.
  always_comb begin
    x_sum_c    = 9'(x_q) + 9'(w_q);
    y_sum_c    = 9'(y_q) + 9'(h_q);
    x_end_c    = (x_sum_c > 9'(FB_W_WORDS)) ? 7'(FB_W_WORDS) : 7'(x_sum_c);
    y_end_c    = (y_sum_c > 9'(FB_H)) ? 7'(FB_H) : 7'(y_sum_c);
    row_base_c = ADDR_W'({y_q, 6'b0}) + ADDR_W'({y_q, 4'b0});
    empty_c    = (w_q == 8'd0) || (h_q == 8'd0) ||
                 (x_q >= 7'(FB_W_WORDS)) || (y_q >= 7'(FB_H));
    last_col_c = (col == x_end - 7'd1);
    last_row_c = (row == y_end - 7'd1);
    accept_c   = cmd_valid & cmd_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_c) state_next = SETUP;
      SETUP:   state_next = empty_c ? DONE : FILL;
      FILL:    if (fill_grant_c && last_col_c && last_row_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fill_req_c  = 1'b0;
    fill_addr_c = row_base + ADDR_W'(col);
    if (state == FILL) fill_req_c = 1'b1;
  end

  // Command latch and raster counters; counters hold while the CPU owns the port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      color    <= '0;
      col      <= '0;
      row      <= '0;
      x_end    <= '0;
      y_end    <= '0;
      row_base <= '0;
    end else begin
      case (state)
        IDLE: if (accept_c) begin
          x_q   <= cmd_x;
          y_q   <= cmd_y;
          w_q   <= cmd_w;
          h_q   <= cmd_h;
          color <= cmd_color;
        end
        SETUP: begin
          col      <= x_q;
          row      <= y_q;
          x_end    <= x_end_c;
          y_end    <= y_end_c;
          row_base <= row_base_c;
        end
        FILL: if (fill_grant_c) begin
          if (last_col_c) begin
            col      <= x_q;
            row      <= row + 7'd1;
            row_base <= row_base + ADDR_W'(FB_W_WORDS);
          end else begin
            col      <= col + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      busy      <= (state_next != IDLE);
      done      <= (state_next == DONE);
      cmd_ready <= (state_next == IDLE);
    end
  end

  vga_fb_arb u_arb (
    .clk          (clk),
    .rst          (rst),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_data     (cpu_data),
    .fill_req     (fill_req_c),
    .fill_addr    (fill_addr_c),
    .fill_data    (color),
    .fill_grant_c (fill_grant_c),
    .fb_addr      (fb_addr),
    .fb_we        (fb_we),
    .fb_data      (fb_data)
  );

endmodule
